// File: rtl/ctrl_bus_client.sv
// Requester-side agent for the 8-slot CTRL_BUS arbiter: turns a local copy command into
// request / queue-ack / grant / BUSY-held memory-to-memory copy / release.
module ctrl_bus_client #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              READY,
  output logic              DONE,
  output logic              ERR,
  output logic              REQUEST,
  input  logic              REQUEST_OK,
  input  logic              EN,
  output logic              BUSY,
  output logic              MEM_RD_EN,
  output logic [ADDR_W-1:0] MEM_RD_ADDR,
  input  logic [DATA_W-1:0] MEM_RD_DATA,
  output logic              MEM_WR_EN,
  output logic [ADDR_W-1:0] MEM_WR_ADDR,
  output logic [DATA_W-1:0] MEM_WR_DATA
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_OK, S_WAIT_EN, S_XFER, S_DRAIN, S_RELEASE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic               grant_now;

  assign READY = (state == S_IDLE);

  // NOTE: read data arrives one cycle after its strobe, exactly when the matching write
  // is issued, so it is forwarded straight through; a register here would skew data by a word.
  assign MEM_WR_DATA = MEM_RD_DATA;

  // Both grant paths (ack+grant together, or grant after ack) enter XFER identically.
  assign grant_now = ((state == S_WAIT_OK) && REQUEST_OK && EN) ||
                     ((state == S_WAIT_EN) && EN);

  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and every
    // register, including the datapath ones, is cleared on the same edge.
    if (RESET) begin
      state       <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      REQUEST     <= 1'b0;
      BUSY        <= 1'b0;
      MEM_RD_EN   <= 1'b0;
      MEM_RD_ADDR <= '0;
      MEM_WR_EN   <= 1'b0;
      MEM_WR_ADDR <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            src_q <= SRC_ADDR;
            dst_q <= DST_ADDR;
            len_q <= LEN;
            ERR   <= 1'b0;
            if (LEN == '0) begin
              DONE <= 1'b1;
            end else begin
              REQUEST <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // The arbiter enqueues on every high cycle, so the request is a single pulse.
          REQUEST <= 1'b0;
          state   <= S_WAIT_OK;
        end
        S_WAIT_OK: begin
          if (REQUEST_OK && !EN) state <= S_WAIT_EN;
        end
        S_WAIT_EN: begin
          if (!REQUEST_OK) ERR <= 1'b1;
        end
        S_XFER: begin
          if (!EN) ERR <= 1'b1;
          MEM_WR_EN <= 1'b1;
          if (MEM_WR_EN) MEM_WR_ADDR <= MEM_WR_ADDR + ADDR_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            MEM_RD_EN <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            cnt         <= cnt + LEN_W'(1);
            MEM_RD_ADDR <= MEM_RD_ADDR + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (!EN) ERR <= 1'b1;
          MEM_WR_EN <= 1'b0;
          BUSY      <= 1'b0;
          state     <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!REQUEST_OK) begin
            DONE  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (grant_now) begin
        state       <= S_XFER;
        BUSY        <= 1'b1;
        MEM_RD_EN   <= 1'b1;
        MEM_RD_ADDR <= src_q;
        MEM_WR_EN   <= 1'b0;
        MEM_WR_ADDR <= dst_q;
        cnt         <= '0;
      end
    end
  end

endmodule

// File: doc/ctrl_bus_client.md
Name: ctrl_bus_client

Overview:
- Requester-side agent for the 8-slot CTRL_BUS arbiter; one instance per requester slot, wired to that slot's REQUEST_x / REQUEST_OK_x / EN_x / BUSY_x.
- Turns a local copy command into the bus protocol: request, wait for queue acceptance, wait for grant, hold BUSY while copying LEN words memory-to-memory, release, wait for acknowledgement to clear.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- LEN_W, 4, transfer-length width; maximum length is 2^LEN_W-1 words.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  command strobe; sampled only while READY=1.
- SRC_ADDR  in  ADDR_W  source base address.
- DST_ADDR  in  ADDR_W  destination base address.
- LEN  in  LEN_W  word count.
- READY  out  1  high in IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky protocol-violation flag; cleared by the next accepted START.
- REQUEST  out  1  bus request to arbiter.
- REQUEST_OK  in  1  arbiter queue acknowledge.
- EN  in  1  arbiter grant.
- BUSY  out  1  transfer in progress; the arbiter releases the slot on its falling edge.
- MEM_RD_EN  out  1  read strobe.
- MEM_RD_ADDR  out  ADDR_W  read address.
- MEM_RD_DATA  in  DATA_W  read data, valid one cycle after MEM_RD_EN.
- MEM_WR_EN  out  1  write strobe.
- MEM_WR_ADDR  out  ADDR_W  write address.
- MEM_WR_DATA  out  DATA_W  write data.

Behaviour:
- Clocking/reset: one clock CLK. RESET is synchronous and active-high. All outputs are registered except READY, which decodes the state.
- Reset values: state=IDLE, READY=1; DONE, ERR, REQUEST, BUSY, MEM_RD_EN and MEM_WR_EN are 0; address, data and count registers are 0. Reset mid-transfer drops REQUEST and BUSY on that edge, with no DONE.
- IDLE: on START=1, latch SRC_ADDR, DST_ADDR and LEN, and clear ERR.
  - LEN=0: DONE=1 the next cycle, stay in IDLE, no bus activity.
  - Otherwise go to REQ.
- REQ: REQUEST=1 for exactly one cycle, because the arbiter enqueues on every cycle REQUEST is high. Then go to WAIT_OK.
- WAIT_OK: hold until REQUEST_OK=1, then go to WAIT_EN. If EN is already 1 in the same cycle, go directly to XFER.
- WAIT_EN: hold until EN=1, then go to XFER. BUSY rises on the entry edge.
- XFER, cycle k (k=0..LEN-1):
  - Read side: MEM_RD_EN=1, MEM_RD_ADDR=SRC+k.
  - Write side, from the second XFER cycle on: MEM_WR_EN=1, MEM_WR_ADDR=DST+k-1, MEM_WR_DATA=MEM_RD_DATA.
  - After the read with k=LEN-1, go to DRAIN.
- DRAIN: MEM_WR_EN=1 for the final word (DST+LEN-1); MEM_RD_EN=0. Then go to RELEASE.
- BUSY is 1 for exactly LEN+1 cycles (XFER+DRAIN), always at least 2, so the arbiter's registered busy sampler sees it high.
- RELEASE: BUSY=0. Hold until REQUEST_OK=0, then pulse DONE=1 for one cycle and return to IDLE. A stale EN=1 in RELEASE or IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFF to 0x00 is legal. The counter is LEN_W bits and does not overflow, since k < LEN.
- Protocol violation: EN=0 during XFER or DRAIN sets ERR=1. The transfer still completes unchanged.
- START while READY=0 is ignored, and the latched command is not altered.
- REQUEST_OK=0 while in WAIT_EN also sets ERR. The block stays in WAIT_EN.

Test Plan:
- Copy SRC=0x10, DST=0x40, LEN=3, mem[0x10..0x12]=A1,B2,C3; arbiter model gives REQUEST_OK after 2 cycles and EN after 5 more. Required: one REQUEST pulse; BUSY high 4 cycles; writes 0x40=A1, 0x41=B2, 0x42=C3; DONE one cycle after REQUEST_OK falls.
- START with LEN=0 → DONE exactly one cycle later; REQUEST, BUSY and memory strobes stay 0.
- SRC=0xFE, DST=0xFF, LEN=3 → reads 0xFE, 0xFF, 0x00; writes 0xFF, 0x00, 0x01.
- Second START pulsed during XFER with different operands → ignored; the original transfer completes; only one DONE.
- RESET asserted on the second XFER cycle of a LEN=5 copy → next cycle BUSY=0, REQUEST=0, READY=1, MEM_WR_EN=0, no DONE. A fresh START then runs normally.
- EN forced low for one XFER cycle → ERR=1 and the transfer still writes all words. ERR is cleared on the next accepted START.
